// File: rtl/ldpcenc_ctl.sv
// Control path for a QC-LDPC encoder: accepts message words, presents them
// through a 3-deep shift register with column/word counters, then sequences parity.
module ldpcenc_ctl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld_in,
   input  logic        sop_in,
   input  logic [3:0]  mode_in,
   input  logic [26:0] data_in,
   output logic        rdy_in,
   output logic [1:0]  state,
   output logic [3:0]  mode,
   output logic [4:0]  cnt_sym,
   output logic [1:0]  cnt_vld,
   output logic [1:0]  cnt_vld_max,
   output logic        clr_acc,
   output logic        vld,
   output logic [26:0] data_r1,
   output logic [26:0] data_r2,
   output logic [26:0] data_r3,
   output logic        vld_out,
   output logic        sop_out,
   output logic        eop_out,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_MSG = 2'd1, S_WAIT = 2'd2, S_PRT = 2'd3} state_t;

   function automatic logic [4:0] info_cols(input logic [1:0] rate);
      case (rate)
         2'd0:    return 5'd12;
         2'd1:    return 5'd16;
         2'd2:    return 5'd18;
         default: return 5'd20;
      endcase
   endfunction

   function automatic logic [4:0] parity_cols(input logic [1:0] rate);
      case (rate)
         2'd0:    return 5'd12;
         2'd1:    return 5'd8;
         2'd2:    return 5'd6;
         default: return 5'd4;
      endcase
   endfunction

   state_t      state_q, state_d;
   logic [3:0]  mode_q, mode_d;
   logic [4:0]  cnt_sym_q, cnt_sym_d;
   logic [1:0]  cnt_vld_q, cnt_vld_d;
   logic        clr_acc_q, clr_acc_d;
   logic        vld_q, vld_d;
   logic [26:0] data_r1_q, data_r1_d;
   logic [26:0] data_r2_q, data_r2_d;
   logic [26:0] data_r3_q, data_r3_d;
   logic        vld_out_q, vld_out_d;
   logic        sop_out_q, sop_out_d;
   logic        eop_out_q, eop_out_d;
   logic        err_q, err_d;
   logic        rdy_q, rdy_d;
   logic        done_q, done_d;
   logic        wait_q, wait_d;

   logic        accept;
   logic [1:0]  vld_max;
   logic [1:0]  vld_step;
   logic [4:0]  sym_step;

   always_comb begin
      accept  = vld_in & rdy_q;
      vld_max = mode_q[3:2];
      // Position that follows the current one: word index wraps into the column index.
      if (cnt_vld_q == vld_max) begin
         vld_step = 2'd0;
         sym_step = cnt_sym_q + 5'd1;
      end else begin
         vld_step = cnt_vld_q + 2'd1;
         sym_step = cnt_sym_q;
      end

      state_d   = state_q;
      mode_d    = mode_q;
      cnt_sym_d = cnt_sym_q;
      cnt_vld_d = cnt_vld_q;
      clr_acc_d = 1'b0;
      vld_d     = 1'b0;
      data_r1_d = data_r1_q;
      data_r2_d = data_r2_q;
      data_r3_d = data_r3_q;
      vld_out_d = vld_q | (state_q == S_PRT);
      sop_out_d = clr_acc_q;
      eop_out_d = 1'b0;
      err_d     = 1'b0;
      done_d    = done_q;
      wait_d    = wait_q;

      if (accept) begin
         data_r1_d = data_in;
         data_r2_d = data_r1_q;
         data_r3_d = data_r2_q;
      end

      case (state_q)
         S_IDLE: begin
            if (accept && sop_in) begin
               mode_d    = {(mode_in[3:2] == 2'd3) ? 2'd2 : mode_in[3:2], mode_in[1:0]};
               state_d   = S_MSG;
               cnt_sym_d = 5'd0;
               cnt_vld_d = 2'd0;
               clr_acc_d = 1'b1;
               vld_d     = 1'b1;
               done_d    = 1'b0;
            end else if (accept) begin
               err_d     = 1'b1;
               data_r1_d = data_r1_q;
               data_r2_d = data_r2_q;
               data_r3_d = data_r3_q;
            end
         end
         S_MSG: begin
            if (accept) begin
               vld_d     = 1'b1;
               err_d     = sop_in;
               cnt_sym_d = sym_step;
               cnt_vld_d = vld_step;
               done_d    = (sym_step == info_cols(mode_q[1:0]) - 5'd1) && (vld_step == vld_max);
            end else if (done_q) begin
               state_d = S_WAIT;
               wait_d  = 1'b0;
            end
         end
         S_WAIT: begin
            wait_d = 1'b1;
            if (wait_q) begin
               state_d   = S_PRT;
               cnt_sym_d = 5'd0;
               cnt_vld_d = 2'd0;
            end
         end
         default: begin
            if ((cnt_sym_q == parity_cols(mode_q[1:0]) - 5'd1) && (cnt_vld_q == vld_max)) begin
               state_d   = S_IDLE;
               eop_out_d = 1'b1;
               cnt_sym_d = 5'd0;
               cnt_vld_d = 2'd0;
            end else begin
               cnt_sym_d = sym_step;
               cnt_vld_d = vld_step;
            end
         end
      endcase

      rdy_d = (state_d == S_IDLE) | ((state_d == S_MSG) & ~done_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         mode_q    <= '0;
         cnt_sym_q <= '0;
         cnt_vld_q <= '0;
         clr_acc_q <= 1'b0;
         vld_q     <= 1'b0;
         data_r1_q <= '0;
         data_r2_q <= '0;
         data_r3_q <= '0;
         vld_out_q <= 1'b0;
         sop_out_q <= 1'b0;
         eop_out_q <= 1'b0;
         err_q     <= 1'b0;
         rdy_q     <= 1'b1;
         done_q    <= 1'b0;
         wait_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         cnt_sym_q <= cnt_sym_d;
         cnt_vld_q <= cnt_vld_d;
         clr_acc_q <= clr_acc_d;
         vld_q     <= vld_d;
         data_r1_q <= data_r1_d;
         data_r2_q <= data_r2_d;
         data_r3_q <= data_r3_d;
         vld_out_q <= vld_out_d;
         sop_out_q <= sop_out_d;
         eop_out_q <= eop_out_d;
         err_q     <= err_d;
         rdy_q     <= rdy_d;
         done_q    <= done_d;
         wait_q    <= wait_d;
      end
   end

   assign rdy_in      = rdy_q;
   assign state       = state_q;
   assign mode        = mode_q;
   assign cnt_sym     = cnt_sym_q;
   assign cnt_vld     = cnt_vld_q;
   assign cnt_vld_max = mode_q[3:2];
   assign clr_acc     = clr_acc_q;
   assign vld         = vld_q;
   assign data_r1     = data_r1_q;
   assign data_r2     = data_r2_q;
   assign data_r3     = data_r3_q;
   assign vld_out     = vld_out_q;
   assign sop_out     = sop_out_q;
   assign eop_out     = eop_out_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ldpcenc_ctl.sv
// Bench for ldpcenc_ctl: word-count based reference model checked every cycle,
// plus literal per-codeword totals.
module tb_ldpcenc_ctl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vld_in = 1'b0;
   logic        sop_in = 1'b0;
   logic [3:0]  mode_in = 4'h0;
   logic [26:0] data_in = '0;
   logic        rdy_in;
   logic [1:0]  state;
   logic [3:0]  mode;
   logic [4:0]  cnt_sym;
   logic [1:0]  cnt_vld;
   logic [1:0]  cnt_vld_max;
   logic        clr_acc;
   logic        vld;
   logic [26:0] data_r1, data_r2, data_r3;
   logic        vld_out, sop_out, eop_out, err;

   ldpcenc_ctl dut (
      .clk(clk), .rst_n(rst_n), .vld_in(vld_in), .sop_in(sop_in), .mode_in(mode_in),
      .data_in(data_in), .rdy_in(rdy_in), .state(state), .mode(mode), .cnt_sym(cnt_sym),
      .cnt_vld(cnt_vld), .cnt_vld_max(cnt_vld_max), .clr_acc(clr_acc), .vld(vld),
      .data_r1(data_r1), .data_r2(data_r2), .data_r3(data_r3), .vld_out(vld_out),
      .sop_out(sop_out), .eop_out(eop_out), .err(err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: tracks words accepted and cycles elapsed after the message.
   int KTAB[4] = '{12, 16, 18, 20};
   int PTAB[4] = '{12, 8, 6, 4};
   int          m_ph = 0;      // 0 idle, 1 message, 2 after message
   int          m_nacc = 0;
   int          m_j = 0;
   int          m_nout = 0;
   int          m_L;
   logic [3:0]  m_mode = 4'h0;
   logic        m_pres = 1'b0, m_err = 1'b0, m_vout = 1'b0, m_sop = 1'b0, m_eop = 1'b0;
   logic        m_fire, m_acc, m_rdy;
   logic [26:0] m_r1 = '0, m_r2 = '0, m_r3 = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph = 0; m_nacc = 0; m_j = 0; m_nout = 0; m_mode = 4'h0;
         m_pres = 0; m_err = 0; m_vout = 0; m_sop = 0; m_eop = 0;
         m_r1 = '0; m_r2 = '0; m_r3 = '0;
      end else begin
         m_L    = int'(m_mode[3:2]) + 1;
         m_fire = m_pres || (m_ph == 2 && m_j >= 3);
         m_vout = m_fire;
         m_sop  = 1'b0;
         m_eop  = 1'b0;
         if (m_fire) begin
            m_sop  = (m_nout == 0);
            m_eop  = (m_nout == 24 * m_L - 1);
            m_nout = m_eop ? 0 : m_nout + 1;
         end
         m_rdy  = (m_ph == 0) || (m_ph == 1 && m_nacc < KTAB[m_mode[1:0]] * m_L);
         m_acc  = vld_in && m_rdy;
         m_pres = 1'b0;
         m_err  = 1'b0;
         case (m_ph)
            0: if (m_acc) begin
               if (sop_in) begin
                  m_mode = {(mode_in[3:2] == 2'd3) ? 2'd2 : mode_in[3:2], mode_in[1:0]};
                  m_ph = 1; m_nacc = 1; m_pres = 1;
                  m_r3 = m_r2; m_r2 = m_r1; m_r1 = data_in;
               end else m_err = 1;
            end
            1: if (m_acc) begin
               m_nacc++; m_pres = 1; m_err = sop_in;
               m_r3 = m_r2; m_r2 = m_r1; m_r1 = data_in;
            end else if (m_nacc == KTAB[m_mode[1:0]] * m_L) begin
               m_ph = 2; m_j = 1;
            end
            default: if (m_j == 2 + PTAB[m_mode[1:0]] * m_L) m_ph = 0; else m_j++;
         endcase
      end
   end

   // Per-cycle comparison and output tallies
   int n_vout = 0, n_eop = 0, n_err = 0, n_prt = 0, n_wait = 0, n_sop = 0;
   logic        cap_done = 1'b0;
   logic [26:0] cap_r1 = '0, cap_r2 = '0, cap_r3 = '0;

   always @(negedge clk) begin
      int L, idx, e_state;
      L = int'(m_mode[3:2]) + 1;
      e_state = (m_ph == 0) ? 0 : (m_ph == 1) ? 1 : (m_j <= 2) ? 2 : 3;
      idx = (m_ph == 1) ? m_nacc - 1 : (m_ph == 2 && m_j >= 3) ? m_j - 3 : 0;
      check("state", 32'(state), 32'(e_state));
      check("rdy_in", 32'(rdy_in),
            32'((m_ph == 0) || (m_ph == 1 && m_nacc < KTAB[m_mode[1:0]] * L)));
      check("mode", 32'(mode), 32'(m_mode));
      check("cnt_vld_max", 32'(cnt_vld_max), 32'(L - 1));
      if (e_state != 2) begin
         check("cnt_sym", 32'(cnt_sym), 32'(idx / L));
         check("cnt_vld", 32'(cnt_vld), 32'(idx % L));
      end
      check("vld", 32'(vld), 32'(m_pres));
      check("clr_acc", 32'(clr_acc), 32'(m_pres && m_nacc == 1));
      check("data_r1", 32'(data_r1), 32'(m_r1));
      check("data_r2", 32'(data_r2), 32'(m_r2));
      check("data_r3", 32'(data_r3), 32'(m_r3));
      check("vld_out", 32'(vld_out), 32'(m_vout));
      check("sop_out", 32'(sop_out), 32'(m_sop));
      check("eop_out", 32'(eop_out), 32'(m_eop));
      check("err", 32'(err), 32'(m_err));
      n_vout += int'(vld_out);
      n_eop  += int'(eop_out);
      n_sop  += int'(sop_out);
      n_err  += int'(err);
      n_prt  += int'(state == 2'd3);
      n_wait += int'(state == 2'd2);
      if (!cap_done && vld && cnt_vld == 2'd2) begin
         cap_done = 1'b1;
         cap_r1 = data_r1; cap_r2 = data_r2; cap_r3 = data_r3;
      end
   end

   task automatic clear_counts();
      @(posedge clk); #1;
      n_vout = 0; n_eop = 0; n_err = 0; n_prt = 0; n_wait = 0; n_sop = 0; cap_done = 1'b0;
   endtask

   task automatic send_codeword(input logic [3:0] md, input int nwords, input int gap, input int sop_at);
      for (int i = 0; i < nwords; i++) begin
         vld_in  = 1'b1;
         sop_in  = (i == 0) || (i == sop_at);
         mode_in = md;
         data_in = 27'(32'h100 + i);
         @(posedge clk); #1;
         vld_in = 1'b0;
         sop_in = 1'b0;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic wait_eop();
      for (int c = 0; c < 400; c++) begin
         if (n_eop > 0) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      check("reset rdy_in", 32'(rdy_in), 32'd1);
      check("reset state", 32'(state), 32'd0);
      check("reset vld_out", 32'(vld_out), 32'd0);
      check("reset cnt_sym", 32'(cnt_sym), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Rate 1/2, 648: 12 words back-to-back
      clear_counts();
      send_codeword(4'h0, 12, 0, -1);
      wait_eop();
      check("m0 out words", 32'(n_vout), 32'd24);
      check("m0 eop", 32'(n_eop), 32'd1);
      check("m0 sop", 32'(n_sop), 32'd1);
      check("m0 wait cycles", 32'(n_wait), 32'd2);
      check("m0 prt cycles", 32'(n_prt), 32'd12);

      // Rate 5/6, 1944: 60 words
      clear_counts();
      send_codeword(4'hB, 60, 0, -1);
      wait_eop();
      check("mB r3 word0", 32'(cap_r3), 32'h100);
      check("mB r2 word1", 32'(cap_r2), 32'h101);
      check("mB r1 word2", 32'(cap_r1), 32'h102);
      check("mB out words", 32'(n_vout), 32'd72);
      check("mB prt cycles", 32'(n_prt), 32'd12);
      check("mB eop", 32'(n_eop), 32'd1);

      // Rate 2/3, 1296 with an idle cycle after each word
      clear_counts();
      send_codeword(4'h5, 32, 1, -1);
      wait_eop();
      check("m5 out words", 32'(n_vout), 32'd48);
      check("m5 prt cycles", 32'(n_prt), 32'd16);
      check("m5 eop", 32'(n_eop), 32'd1);

      // Word without sop in IDLE is dropped with an error pulse
      clear_counts();
      vld_in = 1'b1; sop_in = 1'b0; data_in = 27'h7abcd;
      @(posedge clk); #1;
      vld_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle err count", 32'(n_err), 32'd1);
      check("idle state", 32'(state), 32'd0);
      check("idle no output", 32'(n_vout), 32'd0);

      // sop mid-message is taken as data
      clear_counts();
      send_codeword(4'h0, 12, 0, 5);
      wait_eop();
      check("midsop err count", 32'(n_err), 32'd1);
      check("midsop out words", 32'(n_vout), 32'd24);

      // Reset during parity output aborts the codeword
      clear_counts();
      send_codeword(4'h0, 12, 0, -1);
      for (int c = 0; c < 50; c++) begin
         if (state == 2'd3) break;
         @(posedge clk); #1;
      end
      check("abort reached PRT", 32'(state), 32'd3);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("abort state", 32'(state), 32'd0);
      check("abort rdy_in", 32'(rdy_in), 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("abort no eop", 32'(n_eop), 32'd0);

      // Length code 3 is treated as 1944
      clear_counts();
      send_codeword(4'hF, 60, 0, -1);
      wait_eop();
      check("mF latched mode", 32'(mode), 32'hB);
      check("mF out words", 32'(n_vout), 32'd72);
      check("mF prt cycles", 32'(n_prt), 32'd12);
      check("mF eop", 32'(n_eop), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ldpcenc_ctl.md
LDPCENC_CTL -- requirements
Module: ldpcenc_ctl

Interface
REQ-001 SHALL have no parameters; Z-size and rate are selected at run time by mode_in.
REQ-002 SHALL have these ports (name, direction, width, meaning); reset rst_n, asynchronous, active-low; clock clk:
- clk  in  1  system clock
- rst_n  in  1  asynchronous reset, active low
- vld_in  in  1  input word valid
- sop_in  in  1  first word of codeword message
- mode_in  in  4  [1:0] rate 0..3 = 1/2, 2/3, 3/4, 5/6; [3:2] length 0..2 = 648, 1296, 1944
- data_in  in  27  message word
- rdy_in  out  1  ready; a word is accepted when vld_in&rdy_in
- state  out  2  0 IDLE, 1 MSG, 2 WAIT, 3 PRT
- mode  out  4  latched mode
- cnt_sym  out  5  column index
- cnt_vld  out  2  word index within Z-block
- cnt_vld_max  out  2  words per Z-block minus 1
- clr_acc  out  1  accumulator clear pulse
- vld  out  1  presented word valid
- data_r1, data_r2, data_r3  out  27 each  input word shift register
- vld_out, sop_out, eop_out  out  1 each  output framing, aligned with the datapath's registered output word
- err  out  1  protocol-error pulse

Function
REQ-003 mode SHALL latch mode_in on an accepted sop_in word in IDLE and hold until IDLE is re-entered; mode_in[3:2]=3 SHALL be treated as 2.
REQ-004 cnt_vld_max SHALL equal the latched length code (0, 1, 2).
REQ-005 Info column count K SHALL be 12/16/18/20 and parity column count P 12/8/6/4 for rate 0/1/2/3.
REQ-006 Presentation stage, on each accepted word: data_r1<=data_in, data_r2<=old data_r1, data_r3<=old data_r2; vld<=1 for exactly one cycle.
- In that cycle cnt_vld and cnt_sym SHALL give the presented word's position; cnt_vld wraps at cnt_vld_max, then cnt_sym increments.
REQ-007 IDLE: rdy_in=1; an accepted word with sop_in=1 SHALL be the first message word, SHALL enter MSG, and clr_acc SHALL be 1 in its presentation cycle only.
REQ-008 MSG: rdy_in=1 until the last message word (cnt_sym=K-1, cnt_vld=max) is accepted.
- rdy_in SHALL be 0 from the following cycle until IDLE.
- state SHALL stay MSG through the last word's presentation cycle, then go WAIT.
- Gaps in vld_in SHALL hold all counters.
REQ-009 WAIT SHALL last exactly 2 cycles, then go PRT with cnt_sym=0 and cnt_vld=0.
REQ-010 PRT: one word per cycle; cnt_vld steps 0..max, cnt_sym steps 0..P-1; vld SHALL be 0; no backpressure.
- After cnt_sym=P-1 with cnt_vld=max, the next state SHALL be IDLE.
REQ-011 vld_out SHALL be 1 one cycle after every MSG presentation cycle and every PRT cycle.
- sop_out SHALL mark the first such word; eop_out SHALL mark the last parity word.
- Total output words SHALL be 24*(max+1).
REQ-012 err SHALL pulse one cycle, and the word SHALL be handled as follows:
- accepted vld_in without sop_in in IDLE: word dropped;
- sop_in=1 on an accepted word in MSG: word taken as ordinary data.
REQ-013 A new sop_in SHALL only be accepted once state has returned to IDLE (rdy_in=1).

Reset
REQ-014 Under rst_n=0, all outputs SHALL be 0 except rdy_in, which SHALL be 1 (state IDLE), and all counters SHALL clear.
REQ-015 Reset mid-codeword SHALL abort the codeword with no eop_out; the first post-reset codeword SHALL be processed normally.

Verification
REQ-016 mode_in=0x0, 12 words accepted back-to-back -> WAIT 2 cycles, then 12 PRT cycles; vld_out on 24 words; eop_out on the 24th.
REQ-017 mode_in=0xB (1944, 5/6), 60 words -> cnt_vld cycles 0,1,2; data_r3/r2/r1 = words 0/1/2 when cnt_vld=2; 12 PRT cycles; 72 output words.
REQ-018 mode_in=0x5 (1296, 2/3) with one idle cycle after each input word -> counters hold during gaps; 32 message words, then 16 PRT cycles.
REQ-019 vld_in=1 with sop_in=0 in IDLE -> err pulse, state remains IDLE; sop_in=1 mid-MSG -> err pulse, cnt_sym advances normally.
REQ-020 rst_n low during PRT -> state=0 and rdy_in=1 immediately; eop_out never seen; the next codeword completes with correct counts.
